// File: rtl/clk_switch_ctrl.sv
// Measures clk_1_i against clk_0_i over fixed windows, qualifies it over consecutive
// good windows and drives the registered BUFGMUX select, falling back to clk_0 on faults.
module clk_switch_ctrl #(
   parameter  int WINDOW_CYCLES = 1024,
   parameter  int MIN_EDGES     = 240,
   parameter  int MAX_EDGES     = 272,
   parameter  int GOOD_WINDOWS  = 4,
   parameter  int HOLD_WINDOWS  = 8,
   parameter  int DEAD_CYCLES   = 64,
   localparam int WW            = $clog2(WINDOW_CYCLES),
   localparam int CW            = WW + 1
) (
   input  logic          clk_0_i,
   input  logic          rst_n_i,
   input  logic          clk_1_i,
   input  logic          auto_en_i,
   input  logic          force_clk0_i,
   output logic          select_o,
   output logic          clk1_ok_o,
   output logic          fail_pulse_o,
   output logic [CW-1:0] edge_cnt_o,
   output logic [1:0]    state_o
);

   localparam int DW = $clog2(DEAD_CYCLES + 1);
   localparam int GW = $clog2(GOOD_WINDOWS + 1);
   localparam int HW = $clog2(HOLD_WINDOWS + 1);

   localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW_CYCLES - 1);
   localparam logic [CW-1:0] EDGE_MIN  = CW'(MIN_EDGES);
   localparam logic [CW-1:0] EDGE_MAX  = CW'(MAX_EDGES);
   localparam logic [DW-1:0] DEAD_LIM  = DW'(DEAD_CYCLES);
   localparam logic [GW-1:0] GOOD_LAST = GW'(GOOD_WINDOWS - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_WINDOWS - 1);

   typedef enum logic [1:0] {
      ST_CLK0 = 2'b00,
      ST_QUAL = 2'b01,
      ST_CLK1 = 2'b10,
      ST_HOLD = 2'b11
   } state_t;

   logic          r_tog;
   logic [1:0]    r_sync;
   logic          r_hist;
   logic [WW-1:0] r_win_cnt;
   logic [CW-1:0] r_edge_cnt;
   logic [CW-1:0] r_edge_out;
   logic          r_ok;
   logic [DW-1:0] r_dead_cnt;
   state_t        r_state;
   logic [GW-1:0] r_good_cnt;
   logic [HW-1:0] r_hold_cnt;
   logic          r_select;
   logic          r_fail;

   logic          w_edge_det;
   logic          w_win_end;
   logic [CW-1:0] w_edge_sum;
   logic          w_in_range;
   logic          w_dead;
   logic          w_fault;
   state_t        w_state_nxt;
   logic [GW-1:0] w_good_nxt;
   logic [HW-1:0] w_hold_nxt;
   logic          w_fail_nxt;

   // Only flop in the clk_1 domain: one toggle per clk_1 rising edge.
   always_ff @(posedge clk_1_i or negedge rst_n_i) begin
      if (!rst_n_i) r_tog <= 1'b0;
      else          r_tog <= ~r_tog;
   end

   // NOTE: r_sync[0] may go metastable; nothing but r_sync[1] ever reads it.
   always_ff @(posedge clk_0_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_sync <= '0;
         r_hist <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], r_tog};
         r_hist <= r_sync[1];
      end
   end

   assign w_edge_det = r_sync[1] ^ r_hist;
   assign w_win_end  = (r_win_cnt == WIN_LAST);
   assign w_edge_sum = (w_edge_det && (r_edge_cnt != '1)) ? r_edge_cnt + CW'(1) : r_edge_cnt;
   assign w_in_range = (w_edge_sum >= EDGE_MIN) && (w_edge_sum <= EDGE_MAX);
   assign w_dead     = (r_dead_cnt >= DEAD_LIM);
   assign w_fault    = w_dead || (w_win_end && !w_in_range);

   always_ff @(posedge clk_0_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_win_cnt  <= '0;
         r_edge_cnt <= '0;
         r_edge_out <= '0;
         r_ok       <= 1'b0;
         r_dead_cnt <= '0;
      end else begin
         if (w_win_end) begin
            r_win_cnt  <= '0;
            r_edge_cnt <= '0;
            r_edge_out <= w_edge_sum;
            r_ok       <= w_in_range;
         end else begin
            r_win_cnt  <= r_win_cnt + WW'(1);
            r_edge_cnt <= w_edge_sum;
         end
         if (w_edge_det)              r_dead_cnt <= '0;
         else if (r_dead_cnt != '1)   r_dead_cnt <= r_dead_cnt + DW'(1);
      end
   end

   // Priority: force, then fault, then qualification progress.
   always_comb begin
      // NOTE: every output of this block is defaulted first, so no latch is inferred.
      w_state_nxt = r_state;
      w_good_nxt  = r_good_cnt;
      w_hold_nxt  = r_hold_cnt;
      w_fail_nxt  = 1'b0;
      if (force_clk0_i) begin
         w_state_nxt = ST_CLK0;
         w_good_nxt  = '0;
         w_hold_nxt  = '0;
      end else begin
         case (r_state)
            ST_CLK0: begin
               if (w_win_end && w_in_range && auto_en_i) begin
                  if (GOOD_WINDOWS == 1) begin
                     w_state_nxt = ST_CLK1;
                     w_good_nxt  = '0;
                  end else begin
                     w_state_nxt = ST_QUAL;
                     w_good_nxt  = GW'(1);
                  end
               end
            end
            ST_QUAL: begin
               if (w_fault || !auto_en_i) begin
                  w_state_nxt = ST_CLK0;
                  w_good_nxt  = '0;
               end else if (w_win_end) begin
                  if (r_good_cnt == GOOD_LAST) begin
                     w_state_nxt = ST_CLK1;
                     w_good_nxt  = '0;
                  end else begin
                     w_good_nxt  = r_good_cnt + GW'(1);
                  end
               end
            end
            ST_CLK1: begin
               if (w_fault) begin
                  w_state_nxt = ST_HOLD;
                  w_hold_nxt  = '0;
                  w_fail_nxt  = 1'b1;
               end else if (!auto_en_i) begin
                  w_state_nxt = ST_CLK0;
               end
            end
            ST_HOLD: begin
               if (w_win_end) begin
                  if (r_hold_cnt == HOLD_LAST) begin
                     w_state_nxt = ST_CLK0;
                     w_hold_nxt  = '0;
                  end else begin
                     w_hold_nxt  = r_hold_cnt + HW'(1);
                  end
               end
            end
            default: w_state_nxt = ST_CLK0;
         endcase
      end
   end

   always_ff @(posedge clk_0_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state    <= ST_CLK0;
         r_good_cnt <= '0;
         r_hold_cnt <= '0;
         r_select   <= 1'b0;
         r_fail     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_good_cnt <= w_good_nxt;
         r_hold_cnt <= w_hold_nxt;
         r_select   <= (w_state_nxt == ST_CLK1);
         r_fail     <= w_fail_nxt;
      end
   end

   assign select_o     = r_select;
   assign clk1_ok_o    = r_ok;
   assign fail_pulse_o = r_fail;
   assign edge_cnt_o   = r_edge_out;
   assign state_o      = r_state;

endmodule

// File: doc/clk_switch_ctrl.md
# clk_switch_ctrl

Automatic clock-source controller that generates the registered select for the downstream BUFGMUX-based clock mux. Runs on the always-present clock clk_0_i, measures the frequency of clk_1_i over fixed windows, qualifies it over consecutive good windows, then drives select_o high. It drops back to clk_0 on a frequency fault or a dead clock. Sits beside the clock mux in the clk_rst area; select_o connects directly to the mux select input.

## Interface
- WINDOW_CYCLES, 1024, clk_0_i cycles per measurement window (power of two, ≥ 64)
- MIN_EDGES, 240, lowest acceptable clk_1_i rising-edge count per window
- MAX_EDGES, 272, highest acceptable clk_1_i rising-edge count per window
- GOOD_WINDOWS, 4, consecutive in-range windows required before switching to clk_1
- HOLD_WINDOWS, 8, lockout windows after a fault before requalification starts
- DEAD_CYCLES, 64, clk_0_i cycles with no detected clk_1 edge that signal a dead clock
- clk_0_i  in  1  reference/monitor clock; all logic except the toggle flop
- rst_n_i  in  1  asynchronous, active-low reset (applies to both clk_0_i and clk_1_i flops)
- clk_1_i  in  1  monitored clock; drives only a single toggle flop
- auto_en_i  in  1  allow automatic switch to clk_1 (level, clk_0 domain)
- force_clk0_i  in  1  synchronous override to clk_0, highest priority
- select_o  out  1  registered mux select: 0 = clk_0, 1 = clk_1
- clk1_ok_o  out  1  last completed window was in range
- fail_pulse_o  out  1  one-cycle pulse when a fault forces a return from clk_1
- edge_cnt_o  out  CW  count from the last completed window, where CW = $clog2(WINDOW_CYCLES)+1
- state_o  out  2  00 CLK0, 01 QUAL, 10 CLK1, 11 HOLD

## Operation
- clk_1 domain: tog toggles on every clk_1_i rising edge. It is followed by a 2-flop synchronizer in clk_0_i plus one history flop. edge_det is asserted when the synced value differs from the history flop (one detected edge per clk_1 rising edge). This is valid only for f1 ≤ 0.4·f0.
- Window counter: counts 0..WINDOW_CYCLES-1, free-running from reset. Each edge_det increments the edge counter, which saturates at all-ones.
  - Terminal cycle (win_cnt = WINDOW_CYCLES-1): edge_cnt_o ← the count including this cycle's edge. The edge counter restarts at 0, or 1 if edge_det is also asserted in the first cycle of the new window.
  - clk1_ok_o ← (MIN_EDGES ≤ count ≤ MAX_EDGES).
- Dead counter: cleared on edge_det, otherwise increments and saturates. dead = (dead_cnt ≥ DEAD_CYCLES).
- FSM, evaluated on clk_0_i:
  - CLK0: select_o = 0. At a window end with in-range count and auto_en_i = 1 → QUAL with good_cnt = 1. If GOOD_WINDOWS = 1 → CLK1 directly.
  - QUAL: select_o = 0. In-range window end: good_cnt++; reaching GOOD_WINDOWS → CLK1. Out-of-range window end, dead, or auto_en_i = 0 → CLK0 with good_cnt = 0.
  - CLK1: select_o = 1. Out-of-range window end or dead → HOLD, fail_pulse_o = 1 for one cycle, select_o = 0 next cycle. auto_en_i = 0 → CLK0 with no fail pulse.
  - HOLD: select_o = 0. Counts HOLD_WINDOWS window ends, then → CLK0; window results are ignored while in HOLD.
- force_clk0_i = 1: → CLK0 next cycle with good_cnt and hold_cnt cleared and no fail pulse. Measurement continues.
- Simultaneous events: force beats fault, and fault beats qualification. dead and a window end in the same cycle produce a single transition and a single fail pulse.

## Timing
- Reset values: select_o = 0, clk1_ok_o = 0, fail_pulse_o = 0, edge_cnt_o = 0, state_o = 00, all counters = 0, tog = 0.
- select_o is a flop output; it changes exactly 1 cycle after the deciding window-end, dead, or force cycle.
- clk_1 edge → edge_det latency: 2–3 clk_0_i cycles (synchronizer).
- Minimum time from reset to select_o = 1 is GOOD_WINDOWS complete windows, plus 1 cycle.
- Dead-clock detection: select_o falls at most DEAD_CYCLES+4 cycles after the last clk_1 edge.
- Reset asserted mid-operation: select_o = 0 asynchronously. On release, the window restarts at 0 and no partial count is carried over.

## Test plan
- clk_1 = clk_0/4, auto_en_i = 1 → edge_cnt_o = 255–257 every window, clk1_ok_o = 1, state 00→01→10, select_o rises 1 cycle after the 4th window end (≈ cycle 4096).
- clk_1 = clk_0/3 (≈341 edges) → clk1_ok_o = 0, select_o stays 0, state stays 00.
- Locked on clk_1, then stop clk_1 → fail_pulse_o for exactly one cycle, select_o = 0 within 68 cycles, state 11 for 8 windows, then 00, then requalification once the clock is restored.
- Locked on clk_1, assert force_clk0_i for 1 cycle → select_o = 0 next cycle, no fail pulse, state 00, requalification needs 4 fresh windows.
- In QUAL after 2 good windows, inject one window at clk_0/5 (≈205 edges) → state 00, good_cnt reset, select_o never rises in between.
- Locked on clk_1, pulse rst_n_i low mid-window → select_o = 0 immediately, all outputs at reset values, edge_cnt_o = 0 until the first full window completes.
